iob_pmem_sprite: RTL and testbench
==================================

Name: iob_pmem_sprite

Overview:
Parametrised successor to the VGA pseudo-memory renderer. It draws N_OBJ rectangular sprites over a programmable background. Each sprite has a software-set position, half-size, colour and enable. Sprite registers are double-buffered and committed on frame start, so frames never tear. The pixel path is a 2-stage pipeline with fixed priority and clamped (non-wrapping) bounds. It also records per-object collisions per frame and keeps a frame counter. It sits between the CPU peripheral bus and the VGA timing generator.

Parameters:
N_OBJ, 4, number of sprites (1..8); object 0 has highest priority.
PIX_W, 10, pixel coordinate width.
RGB_W, 12, colour width; must be <= 12.
HLEN_W, 6, half-length field width per axis; must be <= 8.
DATA_W, 32, CPU data width.
ADDR_W, 4, CPU word-address width; 2^ADDR_W must be >= 2*N_OBJ+3.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cpu_valid  in  1  bus request strobe
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  word address
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  read data, valid when cpu_ready=1
cpu_ready  out  1  one-cycle acknowledge
pixel_x  in  PIX_W  current pixel column
pixel_y  in  PIX_W  current pixel row
pixel_valid  in  1  pixel lies in the active area
frame_start  in  1  one-cycle pulse before the first pixel of a frame
rgb  out  RGB_W  pixel colour, 2 cycles after its inputs
rgb_valid  out  1  pixel_valid delayed by 2 cycles

Behaviour:
- Register map (word addresses):
  - 2i = LOC_i: x[9:0], y[19:10], colour[31:20].
  - 2i+1 = SIZE_i: hx[HLEN_W-1:0] at bit 0, hy at bit 8, enable at bit 16.
  - 2N = BG: colour[RGB_W-1:0].
  - 2N+1 = COLL: bit i = object i collided in the last completed frame (read-only).
  - 2N+2 = FRAME: 16-bit frame counter (read-only).
  - Other addresses: read 0, writes ignored. Writes to read-only registers are ignored.
- CPU access: a request with cpu_valid=1 is acknowledged by cpu_ready=1 on the next cycle. cpu_rdata is registered and held until the next read. Back-to-back requests are allowed, one per cycle.
- Shadow/active buffering:
  - CPU writes go to the shadow LOC/SIZE/BG registers. LOC/SIZE/BG reads return shadow values.
  - When frame_start=1, active <= shadow. The active set drives the pixel path.
  - If a write and frame_start occur in the same cycle, active takes the pre-write shadow value; the write applies from the next frame.
- Hit test, per enabled object, using PIX_W+1-bit arithmetic:
  - lo = (o - h) clamped to 0; hi = o + h, with no truncation.
  - Hit when lo <= p <= hi on both axes.
  - Disabled objects never hit.
- Stage 1 (registered): hit vector, pixel_valid.
- Stage 2 (registered):
  - rgb = colour of the lowest-index hit object, else BG. rgb is forced to 0 when the delayed pixel_valid=0.
  - rgb_valid = the delayed pixel_valid.
- Collision:
  - In stage 2, if the delayed pixel_valid=1 and at least 2 hit bits are set, OR those hit bits into the accumulator.
  - On frame_start: COLL <= accumulator (including any same-cycle event), the accumulator clears, and FRAME increments, wrapping from 0xFFFF to 0.
- Reset values: all shadow/active registers, accumulator, COLL, FRAME, pipeline, rgb, rgb_valid, cpu_ready and cpu_rdata are 0. All objects are disabled, so output is black.
- Reset mid-frame flushes the pipeline immediately; the first output after release is valid only 2 cycles after new inputs.

Test Plan:
1. Reset, then drive pixel_valid=1 at (100,100) with BG=0x123 -> rgb=0x000 for the first 2 cycles, then 0x123 with rgb_valid=1; COLL=0, FRAME=0.
2. Write LOC_0={x=50,y=60,col=0xFFF} and SIZE_0={hx=3,hy=3,en=1} without frame_start -> pixel (50,60) still shows BG. After a frame_start pulse -> (47,57) and (53,63) give 0xFFF; (54,60) gives BG.
3. Clamp: object 1 at x=2 with hx=5, committed -> pixel x=0 hits and x=7 hits; pixel x=1020 does not hit (no wrap).
4. Priority/collision: obj0 (col 0xF00) and obj1 (col 0x0F0) overlap at (200,200) -> rgb=0xF00 there. COLL reads 0 until the next frame_start, then 0x3. A frame with no overlap then yields COLL=0.
5. Same-cycle write and frame_start on LOC_0 -> old position is displayed this frame; new position after the following frame_start. FRAME increments by 1 per pulse; after 65536 pulses it reads 0.
6. Assert rst mid-frame while rgb=0xFFF -> rgb=0 and rgb_valid=0 immediately. All registers, including COLL and FRAME, read 0; cpu_ready arrives 1 cycle after each request.

Source files
------------

// File: rtl/iob_pmem_sprite.sv
`default_nettype none
// ============================================================================
// Module   : iob_pmem_sprite
// Purpose  : Sprite renderer for a VGA pixel stream. Draws N_OBJ rectangular,
//            individually enabled sprites over a programmable background.
//            CPU-visible sprite registers are shadowed and committed to the
//            active set on frame_start, so a frame never mixes old and new
//            settings. The pixel path is two registered stages with fixed
//            priority (object 0 on top). Multi-object overlaps are accumulated
//            per frame into COLL, and FRAME counts frame_start pulses.
// Ports    : clk, rst (async, active high)
//            cpu_valid/cpu_we/cpu_addr/cpu_wdata -> cpu_rdata/cpu_ready
//            pixel_x/pixel_y/pixel_valid/frame_start -> rgb/rgb_valid
// Revision : 1.0 - initial release
// ============================================================================
module iob_pmem_sprite #(
    parameter int N_OBJ  = 4,
    parameter int PIX_W  = 10,
    parameter int RGB_W  = 12,
    parameter int HLEN_W = 6,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_valid,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic [PIX_W-1:0]  pixel_x,
    input  logic [PIX_W-1:0]  pixel_y,
    input  logic              pixel_valid,
    input  logic              frame_start,
    output logic [RGB_W-1:0]  rgb,
    output logic              rgb_valid
);

    // Fixed field positions inside the LOC / SIZE words.
    localparam int c_Y_LSB   = 10;
    localparam int c_COL_LSB = 20;
    localparam int c_HY_LSB  = 8;
    localparam int c_EN_BIT  = 16;

    localparam logic [ADDR_W-1:0] c_ADDR_BG    = ADDR_W'(2 * N_OBJ);
    localparam logic [ADDR_W-1:0] c_ADDR_COLL  = ADDR_W'(2 * N_OBJ + 1);
    localparam logic [ADDR_W-1:0] c_ADDR_FRAME = ADDR_W'(2 * N_OBJ + 2);

    // ------------------------------------------------------------------
    // Shadow (CPU side) and active (pixel side) register sets
    // ------------------------------------------------------------------
    logic [PIX_W-1:0]  r_sh_x   [N_OBJ];
    logic [PIX_W-1:0]  r_sh_y   [N_OBJ];
    logic [RGB_W-1:0]  r_sh_col [N_OBJ];
    logic [HLEN_W-1:0] r_sh_hx  [N_OBJ];
    logic [HLEN_W-1:0] r_sh_hy  [N_OBJ];
    logic [N_OBJ-1:0]  r_sh_en;
    logic [RGB_W-1:0]  r_sh_bg;

    logic [PIX_W-1:0]  r_act_x   [N_OBJ];
    logic [PIX_W-1:0]  r_act_y   [N_OBJ];
    logic [RGB_W-1:0]  r_act_col [N_OBJ];
    logic [HLEN_W-1:0] r_act_hx  [N_OBJ];
    logic [HLEN_W-1:0] r_act_hy  [N_OBJ];
    logic [N_OBJ-1:0]  r_act_en;
    logic [RGB_W-1:0]  r_act_bg;

    logic [N_OBJ-1:0]  r_coll_acc;
    logic [N_OBJ-1:0]  r_coll;
    logic [15:0]       r_frame;

    logic [DATA_W-1:0] r_rdata;
    logic              r_ready;

    logic [N_OBJ-1:0]  r_s1_hit;
    logic              r_s1_valid;
    logic [RGB_W-1:0]  r_rgb;
    logic              r_rgb_valid;

    logic [DATA_W-1:0] w_rd;
    logic [N_OBJ-1:0]  w_hit;
    logic [RGB_W-1:0]  w_sel;
    logic [N_OBJ-1:0]  w_coll_evt;

    // ------------------------------------------------------------------
    // CPU read mux (LOC/SIZE/BG return shadow values)
    // ------------------------------------------------------------------
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            if (cpu_addr == ADDR_W'(2 * i)) begin
                w_rd[PIX_W-1:0]             = r_sh_x[i];
                w_rd[c_Y_LSB +: PIX_W]      = r_sh_y[i];
                w_rd[c_COL_LSB +: RGB_W]    = r_sh_col[i];
            end
            if (cpu_addr == ADDR_W'(2 * i + 1)) begin
                w_rd[HLEN_W-1:0]            = r_sh_hx[i];
                w_rd[c_HY_LSB +: HLEN_W]    = r_sh_hy[i];
                w_rd[c_EN_BIT]              = r_sh_en[i];
            end
        end
        if (cpu_addr == c_ADDR_BG)    w_rd[RGB_W-1:0] = r_sh_bg;
        if (cpu_addr == c_ADDR_COLL)  w_rd[N_OBJ-1:0] = r_coll;
        if (cpu_addr == c_ADDR_FRAME) w_rd[15:0]      = r_frame;
    end

    // ------------------------------------------------------------------
    // CPU access, shadow writes and frame-start commit.
    // The commit samples the shadow set before this cycle's write lands,
    // so a write coincident with frame_start takes effect next frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready  <= 1'b0;
            r_rdata  <= '0;
            r_sh_en  <= '0;
            r_sh_bg  <= '0;
            r_act_en <= '0;
            r_act_bg <= '0;
            for (int i = 0; i < N_OBJ; i++) begin
                r_sh_x[i]    <= '0;
                r_sh_y[i]    <= '0;
                r_sh_col[i]  <= '0;
                r_sh_hx[i]   <= '0;
                r_sh_hy[i]   <= '0;
                r_act_x[i]   <= '0;
                r_act_y[i]   <= '0;
                r_act_col[i] <= '0;
                r_act_hx[i]  <= '0;
                r_act_hy[i]  <= '0;
            end
        end else begin
            r_ready <= cpu_valid;
            if (cpu_valid && !cpu_we) begin
                r_rdata <= w_rd;
            end
            if (cpu_valid && cpu_we) begin
                for (int i = 0; i < N_OBJ; i++) begin
                    if (cpu_addr == ADDR_W'(2 * i)) begin
                        r_sh_x[i]   <= cpu_wdata[PIX_W-1:0];
                        r_sh_y[i]   <= cpu_wdata[c_Y_LSB +: PIX_W];
                        r_sh_col[i] <= cpu_wdata[c_COL_LSB +: RGB_W];
                    end
                    if (cpu_addr == ADDR_W'(2 * i + 1)) begin
                        r_sh_hx[i]  <= cpu_wdata[HLEN_W-1:0];
                        r_sh_hy[i]  <= cpu_wdata[c_HY_LSB +: HLEN_W];
                        r_sh_en[i]  <= cpu_wdata[c_EN_BIT];
                    end
                end
                if (cpu_addr == c_ADDR_BG) begin
                    r_sh_bg <= cpu_wdata[RGB_W-1:0];
                end
            end
            if (frame_start) begin
                r_act_en <= r_sh_en;
                r_act_bg <= r_sh_bg;
                for (int i = 0; i < N_OBJ; i++) begin
                    r_act_x[i]   <= r_sh_x[i];
                    r_act_y[i]   <= r_sh_y[i];
                    r_act_col[i] <= r_sh_col[i];
                    r_act_hx[i]  <= r_sh_hx[i];
                    r_act_hy[i]  <= r_sh_hy[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Hit test. One extra bit keeps o+h from wrapping; the low bound is
    // clamped at 0 instead of underflowing.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_hit
            logic [PIX_W:0] w_ox, w_oy, w_hx, w_hy;
            logic [PIX_W:0] w_lo_x, w_hi_x, w_lo_y, w_hi_y;
            logic [PIX_W:0] w_px, w_py;

            assign w_ox   = {1'b0, r_act_x[gi]};
            assign w_oy   = {1'b0, r_act_y[gi]};
            assign w_hx   = {{(PIX_W + 1 - HLEN_W){1'b0}}, r_act_hx[gi]};
            assign w_hy   = {{(PIX_W + 1 - HLEN_W){1'b0}}, r_act_hy[gi]};
            assign w_px   = {1'b0, pixel_x};
            assign w_py   = {1'b0, pixel_y};
            assign w_lo_x = (w_ox >= w_hx) ? (w_ox - w_hx) : '0;
            assign w_lo_y = (w_oy >= w_hy) ? (w_oy - w_hy) : '0;
            assign w_hi_x = w_ox + w_hx;
            assign w_hi_y = w_oy + w_hy;

            assign w_hit[gi] = r_act_en[gi]
                             && (w_lo_x <= w_px) && (w_px <= w_hi_x)
                             && (w_lo_y <= w_py) && (w_py <= w_hi_y);
        end
    endgenerate

    // Lowest-index hit wins: iterate high to low so index 0 is written last.
    always_comb begin
        w_sel = r_act_bg;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (r_s1_hit[i]) w_sel = r_act_col[i];
        end
    end

    // x & (x-1) is non-zero exactly when two or more bits are set.
    assign w_coll_evt = (r_s1_valid && (|(r_s1_hit & (r_s1_hit - 1'b1))))
                      ? r_s1_hit : '0;

    // ------------------------------------------------------------------
    // Pixel pipeline, collision accumulator and frame counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_hit    <= '0;
            r_s1_valid  <= 1'b0;
            r_rgb       <= '0;
            r_rgb_valid <= 1'b0;
            r_coll_acc  <= '0;
            r_coll      <= '0;
            r_frame     <= '0;
        end else begin
            r_s1_hit    <= w_hit;
            r_s1_valid  <= pixel_valid;
            r_rgb       <= r_s1_valid ? w_sel : '0;
            r_rgb_valid <= r_s1_valid;
            if (frame_start) begin
                r_coll     <= r_coll_acc | w_coll_evt;
                r_coll_acc <= '0;
                r_frame    <= r_frame + 16'd1;
            end else begin
                r_coll_acc <= r_coll_acc | w_coll_evt;
            end
        end
    end

    assign cpu_rdata = r_rdata;
    assign cpu_ready = r_ready;
    assign rgb       = r_rgb;
    assign rgb_valid = r_rgb_valid;

endmodule
`default_nettype wire

// File: tb/tb_iob_pmem_sprite.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_pmem_sprite
// Purpose  : Directed self-checking bench for iob_pmem_sprite: background,
//            sprite commit, clamped bounds, priority, collision reporting,
//            same-cycle write/commit, frame counter wrap, async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iob_pmem_sprite;

    localparam int c_N = 4;
    localparam logic [3:0] c_BG    = 4'd8;
    localparam logic [3:0] c_COLL  = 4'd9;
    localparam logic [3:0] c_FRAME = 4'd10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_valid = 1'b0;
    logic        cpu_we = 1'b0;
    logic [3:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic        pixel_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic [11:0] rgb;
    logic        rgb_valid;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] r_val;

    iob_pmem_sprite #(
        .N_OBJ(c_N), .PIX_W(10), .RGB_W(12), .HLEN_W(6), .DATA_W(32), .ADDR_W(4)
    ) u_dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
        .frame_start(frame_start), .rgb(rgb), .rgb_valid(rgb_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] loc(input int x, input int y, input int col);
        logic [31:0] xv, yv, cv;
        xv = x; yv = y; cv = col;
        return {cv[11:0], yv[9:0], xv[9:0]};
    endfunction

    function automatic logic [31:0] size(input int hx, input int hy, input bit en);
        logic [31:0] hxv, hyv;
        hxv = hx; hyv = hy;
        return {15'b0, en, 2'b0, hyv[5:0], 2'b0, hxv[5:0]};
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        @(posedge clk); #1;
        cpu_valid = 1'b0; cpu_we = 1'b0;
        chk("wr_ready", {31'b0, cpu_ready}, 32'd1);
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        @(posedge clk); #1;
        cpu_valid = 1'b0;
        chk("rd_ready", {31'b0, cpu_ready}, 32'd1);
        d = cpu_rdata;
    endtask

    task automatic frame;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic pix(input string tag, input int x, input int y, input logic [11:0] exp);
        pixel_x = 10'(x); pixel_y = 10'(y); pixel_valid = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk(tag, {20'b0, rgb}, {20'b0, exp});
        chk({tag, "_vld"}, {31'b0, rgb_valid}, 32'd1);
    endtask

    initial begin
        // ---- reset state ----
        #12;
        chk("rst_rgb", {20'b0, rgb}, 32'd0);
        chk("rst_vld", {31'b0, rgb_valid}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        bus_rd(c_COLL, r_val);  chk("t1_coll", r_val, 32'd0);
        bus_rd(c_FRAME, r_val); chk("t1_frame", r_val, 32'd0);
        @(posedge clk); #1;
        chk("ready_idle", {31'b0, cpu_ready}, 32'd0);

        // ---- 1: background ----
        bus_wr(c_BG, 32'h123);
        bus_rd(c_BG, r_val); chk("bg_rdback", r_val, 32'h123);
        frame;
        pixel_x = 10'd100; pixel_y = 10'd100; pixel_valid = 1'b1;
        @(posedge clk); #1;
        chk("t1_lat_rgb", {20'b0, rgb}, 32'd0);
        chk("t1_lat_vld", {31'b0, rgb_valid}, 32'd0);
        @(posedge clk); #1;
        chk("t1_bg", {20'b0, rgb}, 32'h123);
        chk("t1_bg_vld", {31'b0, rgb_valid}, 32'd1);

        // ---- 2: shadow then commit ----
        bus_wr(4'd0, loc(50, 60, 12'hFFF));
        bus_wr(4'd1, size(3, 3, 1'b1));
        bus_rd(4'd0, r_val); chk("loc0_rdback", r_val, 32'hFFF0F032);
        bus_rd(4'd1, r_val); chk("size0_rdback", r_val, 32'h00010303);
        pix("t2_precommit", 50, 60, 12'h123);
        frame;
        pix("t2_corner_lo", 47, 57, 12'hFFF);
        pix("t2_corner_hi", 53, 63, 12'hFFF);
        pix("t2_outside_x", 54, 60, 12'h123);
        pix("t2_outside_y", 50, 56, 12'h123);

        // ---- 3: clamp at left edge, no wrap ----
        bus_wr(4'd2, loc(2, 300, 12'h0F0));
        bus_wr(4'd3, size(5, 0, 1'b1));
        frame;
        pix("t3_x0", 0, 300, 12'h0F0);
        pix("t3_x7", 7, 300, 12'h0F0);
        pix("t3_x8", 8, 300, 12'h123);
        pix("t3_x1020", 1020, 300, 12'h123);
        pix("t3_y301", 3, 301, 12'h123);

        // ---- 4: priority and collision ----
        bus_wr(4'd0, loc(200, 200, 12'hF00));
        bus_wr(4'd1, size(3, 3, 1'b1));
        bus_wr(4'd2, loc(202, 200, 12'h0F0));
        bus_wr(4'd3, size(3, 3, 1'b1));
        frame;
        pix("t4_overlap", 200, 200, 12'hF00);
        pix("t4_obj1_only", 205, 200, 12'h0F0);
        pix("t4_overlap2", 201, 199, 12'hF00);
        pixel_valid = 1'b0;
        bus_rd(c_COLL, r_val); chk("t4_coll_pre", r_val, 32'd0);
        frame;
        bus_rd(c_COLL, r_val); chk("t4_coll", r_val, 32'h3);
        frame;
        bus_rd(c_COLL, r_val); chk("t4_coll_clear", r_val, 32'd0);
        bus_rd(c_FRAME, r_val); chk("t4_frame", r_val, 32'd6);

        // ---- 5: write coincident with frame_start ----
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd0;
        cpu_wdata = loc(400, 400, 12'hF00); frame_start = 1'b1;
        @(posedge clk); #1;
        cpu_valid = 1'b0; cpu_we = 1'b0; frame_start = 1'b0;
        chk("t5_ready", {31'b0, cpu_ready}, 32'd1);
        pix("t5_old_pos", 200, 200, 12'hF00);
        pix("t5_new_pending", 400, 400, 12'h123);
        frame;
        pix("t5_new_pos", 400, 400, 12'hF00);
        pix("t5_old_gone", 200, 200, 12'h0F0);
        bus_rd(c_FRAME, r_val); chk("t5_frame", r_val, 32'd8);
        frame_start = 1'b1;
        repeat (65528) @(posedge clk);
        #1 frame_start = 1'b0;
        bus_rd(c_FRAME, r_val); chk("t5_frame_wrap", r_val, 32'd0);

        // ---- 6: async reset mid-frame ----
        bus_wr(4'd0, loc(400, 400, 12'hFFF));
        frame;
        pix("t6_pre_rst", 400, 400, 12'hFFF);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_rgb", {20'b0, rgb}, 32'd0);
        chk("t6_rst_vld", {31'b0, rgb_valid}, 32'd0);
        chk("t6_rst_ready", {31'b0, cpu_ready}, 32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        bus_rd(c_COLL, r_val);  chk("t6_coll", r_val, 32'd0);
        bus_rd(c_FRAME, r_val); chk("t6_frame", r_val, 32'd0);
        bus_rd(4'd0, r_val);    chk("t6_loc0", r_val, 32'd0);
        bus_rd(4'd1, r_val);    chk("t6_size0", r_val, 32'd0);
        bus_rd(c_BG, r_val);    chk("t6_bg", r_val, 32'd0);
        pix("t6_black", 400, 400, 12'h000);
        bus_wr(c_FRAME, 32'h1234);
        bus_rd(c_FRAME, r_val); chk("ro_frame", r_val, 32'd0);
        bus_wr(4'd15, 32'hFFFF_FFFF);
        bus_rd(4'd15, r_val);   chk("unmapped", r_val, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    // Absolute time limit so a stuck run still terminates.
    initial begin
        #2_000_000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
